// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of datapath-facing signals for the pipeline hazard controller.
// master = datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             ResultSrcE0, PCJalSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             dmem_req, timeout_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE0, PCJalSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, dmem_req, timeout_err, stall_cycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE0, PCJalSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, dmem_req, timeout_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32 pipeline, including the
// multi-cycle data-memory wait FSM with timeout and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              mem_stall, lw_stall;

    assign mem_stall = ((state_q == RUN) && hz.MemReqM && !hz.dmem_ready)
                     || ((state_q == MEM_WAIT) && !hz.dmem_ready)
                     || (state_q == TIMEOUT);

    assign lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0)
                    && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            timeout_err_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_err_q  <= timeout_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // wait_cnt is nonzero only while in MEM_WAIT; TIMEOUT is left only through reset.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            RUN: begin
                if (hz.MemReqM && !hz.dmem_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = TIMEOUT;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        stall_cycles_d = stall_cycles_q;
        if ((mem_stall || lw_stall) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // A memory stall freezes EX, so branch flushes and load-use stalls re-evaluate after release.
    always_comb begin
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.StallM    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushW    = 1'b0;
        hz.dmem_req  = 1'b0;
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (!reset) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
            hz.FlushW = 1'b1;
        end else begin
            hz.dmem_req = hz.MemReqM && (state_q != TIMEOUT);
            if (mem_stall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.FlushW = 1'b1;
            end else begin
                hz.StallF = lw_stall;
                hz.StallD = lw_stall;
                hz.FlushE = lw_stall || hz.PCJalSrcE;
                hz.FlushD = hz.PCJalSrcE;
            end

            if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E)) begin
                hz.ForwardAE = 2'b10;
            end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E)) begin
                hz.ForwardAE = 2'b01;
            end

            if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E)) begin
                hz.ForwardBE = 2'b10;
            end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E)) begin
                hz.ForwardBE = 2'b01;
            end
        end
    end

    assign hz.timeout_err  = timeout_err_q;
    assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios with fixed expectations,
// then randomized traffic checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 16;

    logic clk = 1'b0;
    logic reset;
    int   total_checks = 0;
    int   bad_checks   = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    always #5 clk = ~clk;

    // Model state: an outstanding access, how many wait cycles it has burned, frozen flag.
    bit m_waiting, m_dead, m_err;
    int m_waited, m_stalls;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_vec();
        return {hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.StallM,
                hz_if.FlushD, hz_if.FlushE, hz_if.FlushW, hz_if.dmem_req};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz_if.Rs1D = 0; hz_if.Rs2D = 0; hz_if.Rs1E = 0; hz_if.Rs2E = 0;
        hz_if.RdE = 0; hz_if.RdM = 0; hz_if.RdW = 0;
        hz_if.ResultSrcE0 = 0; hz_if.PCJalSrcE = 0; hz_if.RegWriteM = 0;
        hz_if.RegWriteW = 0; hz_if.MemReqM = 0; hz_if.dmem_ready = 0;
    endtask

    task automatic applyStimulus(input int ready_mode);
        hz_if.Rs1D = 5'($urandom_range(0, 7));
        hz_if.Rs2D = 5'($urandom_range(0, 7));
        hz_if.Rs1E = 5'($urandom_range(0, 7));
        hz_if.Rs2E = 5'($urandom_range(0, 7));
        hz_if.RdE  = 5'($urandom_range(0, 7));
        hz_if.RdM  = 5'($urandom_range(0, 7));
        hz_if.RdW  = 5'($urandom_range(0, 7));
        hz_if.ResultSrcE0 = ($urandom_range(0, 3) == 0);
        hz_if.PCJalSrcE   = !hz_if.ResultSrcE0 && ($urandom_range(0, 5) == 0);
        hz_if.RegWriteM   = $urandom_range(0, 1) == 1;
        hz_if.RegWriteW   = $urandom_range(0, 1) == 1;
        hz_if.MemReqM     = ($urandom_range(0, 2) == 0);
        case (ready_mode)
            0:       hz_if.dmem_ready = 1'b0;
            1:       hz_if.dmem_ready = ($urandom_range(0, 3) == 0);
            2:       hz_if.dmem_ready = ($urandom_range(0, 3) != 0);
            default: hz_if.dmem_ready = 1'b1;
        endcase
        reset = ($urandom_range(0, 49) != 0);
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (hz_if.RegWriteM && hz_if.RdM != 0 && hz_if.RdM == rs) return 2'b10;
        if (hz_if.RegWriteW && hz_if.RdW != 0 && hz_if.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Check the current cycle against the model, then advance the model across the edge.
    task automatic model_cycle();
        bit         memst, lw, req;
        logic [7:0] exp_ctrl;
        logic [1:0] exp_a, exp_b;
        #2;
        memst = m_dead || (!hz_if.dmem_ready && (m_waiting || hz_if.MemReqM));
        lw    = hz_if.ResultSrcE0 && hz_if.RdE != 0 &&
                (hz_if.RdE == hz_if.Rs1D || hz_if.RdE == hz_if.Rs2D);
        req   = hz_if.MemReqM && !m_dead;
        if (!reset) begin
            exp_ctrl = 8'b0000_1110;
            exp_a    = 2'b00;
            exp_b    = 2'b00;
        end else begin
            if (memst) exp_ctrl = {4'b1111, 2'b00, 1'b1, req};
            else       exp_ctrl = {lw, lw, 2'b00, hz_if.PCJalSrcE, lw | hz_if.PCJalSrcE, 1'b0, req};
            exp_a = fwd_ref(hz_if.Rs1E);
            exp_b = fwd_ref(hz_if.Rs2E);
        end
        checkOutput("ctrl", 32'(ctrl_vec()), 32'(exp_ctrl));
        checkOutput("fwdA", 32'(hz_if.ForwardAE), 32'(exp_a));
        checkOutput("fwdB", 32'(hz_if.ForwardBE), 32'(exp_b));
        checkOutput("stallcnt", 32'(hz_if.stall_cycles), 32'(m_stalls));
        checkOutput("terr", 32'(hz_if.timeout_err), 32'(m_err));
        @(posedge clk);
        if (!reset) begin
            m_waiting = 0; m_dead = 0; m_err = 0; m_waited = 0; m_stalls = 0;
        end else begin
            if ((memst || lw) && m_stalls < (2 ** CNT_W) - 1) m_stalls++;
            if (m_dead) begin
            end else if (m_waiting) begin
                if (hz_if.dmem_ready) begin
                    m_waiting = 0;
                end else begin
                    m_waited++;
                    if (m_waited == MEM_TIMEOUT) begin
                        m_waiting = 0; m_dead = 1; m_err = 1;
                    end
                end
            end else if (hz_if.MemReqM && !hz_if.dmem_ready) begin
                m_waiting = 1;
                m_waited  = 0;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #2;
        checkOutput("rst_ctrl", 32'(ctrl_vec()), 32'h0E);
        tick();
        reset = 1'b1;
        #2;
        checkOutput("rst_cnt", 32'(hz_if.stall_cycles), 0);
        checkOutput("rst_terr", 32'(hz_if.timeout_err), 0);

        hz_if.ResultSrcE0 = 1; hz_if.RdE = 5; hz_if.Rs1D = 5;
        #1;
        checkOutput("lu_stall", 32'(ctrl_vec()), 32'hC4);
        tick();
        hz_if.Rs1D = 0;
        #2;
        checkOutput("lu_cnt", 32'(hz_if.stall_cycles), 1);
        checkOutput("lu_none", 32'(ctrl_vec()), 32'h00);
        tick();
        clear_inputs();
        hz_if.PCJalSrcE = 1;
        #2;
        checkOutput("jal", 32'(ctrl_vec()), 32'h0C);
        tick();

        clear_inputs();
        hz_if.MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            hz_if.PCJalSrcE = (i >= 1);
            #2;
            checkOutput("mem_wait", 32'(ctrl_vec()), 32'hF3);
            tick();
        end
        hz_if.dmem_ready = 1;
        #2;
        checkOutput("mem_release", 32'(ctrl_vec()), 32'h0D);
        tick();
        hz_if.PCJalSrcE = 0;
        #2;
        checkOutput("mem_zero", 32'(ctrl_vec()), 32'h01);
        checkOutput("mem_cnt", 32'(hz_if.stall_cycles), 4);
        tick();

        hz_if.dmem_ready = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) tick();
        #1;
        checkOutput("to_before", 32'(hz_if.timeout_err), 0);
        tick();
        #1;
        checkOutput("to_err", 32'(hz_if.timeout_err), 1);
        checkOutput("to_ctrl", 32'(ctrl_vec()), 32'hF2);
        reset = 0;
        tick();
        reset = 1; hz_if.MemReqM = 0;
        #2;
        checkOutput("to_clr", 32'(hz_if.timeout_err), 0);
        checkOutput("to_cnt", 32'(hz_if.stall_cycles), 0);
        checkOutput("to_run", 32'(ctrl_vec()), 32'h00);

        clear_inputs();
        hz_if.RdM = 7; hz_if.RdW = 7; hz_if.RegWriteM = 1; hz_if.RegWriteW = 1; hz_if.Rs1E = 7;
        #1;
        checkOutput("fwd_mem", 32'({hz_if.ForwardAE, hz_if.ForwardBE}), 32'b1000);
        hz_if.RegWriteM = 0;
        #1;
        checkOutput("fwd_wb", 32'({hz_if.ForwardAE, hz_if.ForwardBE}), 32'b0100);
        tick();

        reset = 0;
        tick();
        m_waiting = 0; m_dead = 0; m_err = 0; m_waited = 0; m_stalls = 0;
        for (int p = 0; p < 60; p++) begin
            int mode;
            mode = $urandom_range(0, 3);
            for (int c = 0; c < 40; c++) begin
                applyStimulus(mode);
                model_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
